// File: rtl/bus_transfer_unit.sv
// bus_transfer_unit: drives the shared Mini SRC bus from queued transfer
// requests. Each request names one source word and one destination register.
// A 2-entry FIFO holds waiting requests. An IDLE/SELECT/DRIVE sequencer
// validates the request, registers the selected word onto BusMuxOut, and then
// pulses the destination enable for one cycle.
module bus_transfer_unit #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int NDST  = 24
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [NSRC*WIDTH-1:0]   BusMuxIn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NSRC-1:0]         req_src,
  input  logic [NDST-1:0]         req_dst,
  output logic [WIDTH-1:0]        BusMuxOut,
  output logic [NDST-1:0]         reg_enable,
  output logic                    done,
  output logic                    err,
  output logic                    busy
);

  localparam int ENTW = NSRC + NDST;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_DRIVE  = 2'd2
  } state_t;

  // True when exactly one bit of a source select is set.
  function automatic logic src_onehot(input logic [NSRC-1:0] v);
    return (v != '0) && ((v & (v - {{(NSRC-1){1'b0}}, 1'b1})) == '0);
  endfunction

  // True when exactly one bit of a destination select is set.
  function automatic logic dst_onehot(input logic [NDST-1:0] v);
    return (v != '0) && ((v & (v - {{(NDST-1){1'b0}}, 1'b1})) == '0);
  endfunction

  state_t            state_q, state_d;
  logic [ENTW-1:0]   mem_q [2];
  logic [ENTW-1:0]   mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ENTW-1:0]   cur_q, cur_d;
  logic [WIDTH-1:0]  bus_q, bus_d;
  logic [NDST-1:0]   en_q, en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              push_s, pop_s, head_avail_s, wr_idx_s;
  logic [ENTW-1:0]   head_s;
  logic [NSRC-1:0]   cur_src_s;
  logic [NDST-1:0]   cur_dst_s;
  logic [WIDTH-1:0]  sel_word_s;

  // Readiness depends on the registered count only, so a full FIFO never takes a push.
  assign req_ready = (count_q < 2'd2) && !clear;

  assign BusMuxOut  = bus_q;
  assign reg_enable = en_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

  // Sequencer next state, FIFO bookkeeping and per-transfer outputs.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cur_d    = cur_q;
    bus_d    = bus_q;
    en_d     = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pop_s    = 1'b0;

    push_s       = req_valid && req_ready;
    // An empty FIFO lets an incoming request go straight to SELECT.
    head_s       = (count_q != 2'd0) ? mem_q[rd_ptr_q] : {req_src, req_dst};
    head_avail_s = (count_q != 2'd0) || push_s;
    wr_idx_s     = rd_ptr_q ^ count_q[0];

    cur_src_s  = cur_q[ENTW-1:NDST];
    cur_dst_s  = cur_q[NDST-1:0];
    sel_word_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (cur_src_s[i]) begin
        sel_word_s = sel_word_s | BusMuxIn[i*WIDTH +: WIDTH];
      end else begin
        sel_word_s = sel_word_s;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (head_avail_s) begin
          pop_s   = 1'b1;
          cur_d   = head_s;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (src_onehot(cur_src_s) && dst_onehot(cur_dst_s)) begin
          bus_d   = sel_word_s;
          en_d    = cur_dst_s;
          done_d  = 1'b1;
          state_d = ST_DRIVE;
        end else if (head_avail_s) begin
          err_d   = 1'b1;
          pop_s   = 1'b1;
          cur_d   = head_s;
          state_d = ST_SELECT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (head_avail_s) begin
          pop_s   = 1'b1;
          cur_d   = head_s;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A bypassed request (push and pop into an empty FIFO) never occupies a slot.
    if (push_s && !(pop_s && (count_q == 2'd0))) begin
      mem_d[wr_idx_s] = {req_src, req_dst};
    end else begin
      mem_d = mem_d;
    end

    if (pop_s && (count_q != 2'd0)) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    busy_d  = (count_d != 2'd0) || (state_d != ST_IDLE);
  end

  // State, FIFO and output registers; clear aborts everything in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cur_q    <= '0;
      bus_q    <= '0;
      en_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      bus_q    <= bus_d;
      en_q     <= en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_bus_transfer_unit.sv
// Bench for bus_transfer_unit. A register-file model feeds BusMuxIn and loads
// from BusMuxOut when its enable pulses. A transaction-level reference model
// predicts the unit's observable behaviour.
module tb_bus_transfer_unit;

  localparam int W  = 32;
  localparam int NS = 24;
  localparam int ND = 24;

  logic              clock = 1'b0;
  logic              clear;
  logic [NS*W-1:0]   bus_in;
  logic              req_valid;
  logic              req_ready;
  logic [NS-1:0]     req_src;
  logic [ND-1:0]     req_dst;
  logic [W-1:0]      bus_out;
  logic [ND-1:0]     reg_enable;
  logic              done;
  logic              err;
  logic              busy;

  bus_transfer_unit #(.WIDTH(W), .NSRC(NS), .NDST(ND)) dut (
    .clock      (clock),
    .clear      (clear),
    .BusMuxIn   (bus_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .BusMuxOut  (bus_out),
    .reg_enable (reg_enable),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int ncmp = 0;
  int nfail = 0;

  // Register file seen by the bus: word i drives BusMuxIn slot i.
  logic [W-1:0]      regs [NS];

  // Reference model state.
  logic [NS+ND-1:0]  pend [$];
  logic              sel_act = 1'b0;
  logic [NS-1:0]     sel_src;
  logic [ND-1:0]     sel_dst;
  logic [W-1:0]      m_bus = '0;
  logic [ND-1:0]     m_en = '0;
  logic              m_done = 1'b0;
  logic              m_err = 1'b0;
  logic              m_busy = 1'b0;
  logic              ld_pend = 1'b0;
  int                ld_idx = 0;
  logic [W-1:0]      ld_val = '0;

  function automatic logic [NS-1:0] oh(input int i);
    logic [NS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh_idx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: apply stimulus at the falling edge, update the model at
  // the rising edge, and check outputs at the next falling edge.
  task automatic tick(input logic v, input logic [NS-1:0] s, input logic [ND-1:0] d,
                      input logic c, input logic scr, output logic acc);
    logic             exp_ready;
    logic             drive_now;
    logic [ND-1:0]    nx_en;
    logic             nx_done;
    logic             nx_err;
    logic [NS+ND-1:0] ent;
    if (scr) regs[$urandom_range(0, NS-1)] = $urandom;
    for (int i = 0; i < NS; i++) bus_in[i*W +: W] = regs[i];
    req_valid = v;
    req_src   = s;
    req_dst   = d;
    clear     = c;
    #1;
    exp_ready = !c && (pend.size() < 2);
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    acc = v && exp_ready;
    @(posedge clock);
    // A drive cycle ending at this edge loads its destination register.
    if (m_en != '0) begin
      ld_pend = 1'b1;
      ld_idx  = oh_idx(m_en);
      ld_val  = m_bus;
    end
    if (c) begin
      pend.delete();
      sel_act = 1'b0;
      m_bus   = '0;
      m_en    = '0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_busy  = 1'b0;
    end else begin
      drive_now = 1'b0;
      nx_en     = '0;
      nx_done   = 1'b0;
      nx_err    = 1'b0;
      if (sel_act) begin
        if ($countones(sel_src) == 1 && $countones(sel_dst) == 1) begin
          m_bus     = regs[oh_idx(sel_src)];
          nx_en     = sel_dst;
          nx_done   = 1'b1;
          drive_now = 1'b1;
        end else begin
          nx_err = 1'b1;
        end
      end
      if (acc) pend.push_back({s, d});
      sel_act = 1'b0;
      if (!drive_now && pend.size() > 0) begin
        ent     = pend.pop_front();
        sel_src = ent[NS+ND-1:ND];
        sel_dst = ent[ND-1:0];
        sel_act = 1'b1;
      end
      m_en   = nx_en;
      m_done = nx_done;
      m_err  = nx_err;
      m_busy = (pend.size() > 0) || sel_act || drive_now;
    end
    @(negedge clock);
    chk("BusMuxOut", bus_out, m_bus);
    chk("reg_enable", {8'd0, reg_enable}, {8'd0, m_en});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (ld_pend) begin
      regs[ld_idx] = ld_val;
      ld_pend = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0, a);
  endtask

  initial begin
    logic          acc;
    logic          rv;
    logic          rc;
    logic [31:0]   t32;
    logic [NS-1:0] rs;
    logic [ND-1:0] rd;

    for (int i = 0; i < NS; i++) regs[i] = $urandom;
    clear     = 1'b1;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    bus_in    = '0;
    @(negedge clock);

    // Reset held two cycles with a request offered: nothing accepted.
    tick(1'b1, oh(3), oh(5), 1'b1, 1'b0, acc);
    tick(1'b1, oh(3), oh(5), 1'b1, 1'b0, acc);
    chk("reset_bus", bus_out, 32'h0);
    idle(1);

    // Single transfer: word 3 into register 5.
    regs[3] = 32'hDEADBEEF;
    tick(1'b1, oh(3), oh(5), 1'b0, 1'b0, acc);
    idle(1);
    chk("single_bus", bus_out, 32'hDEADBEEF);
    chk("single_en", {8'd0, reg_enable}, 32'h0000_0020);
    idle(2);

    // Back-to-back hazard: R1 <- word 2, then R4 <- R1.
    regs[2] = 32'h12345678;
    regs[1] = 32'h0BADF00D;
    tick(1'b1, oh(2), oh(1), 1'b0, 1'b0, acc);
    tick(1'b1, oh(1), oh(4), 1'b0, 1'b0, acc);
    idle(5);
    chk("hazard_bus", bus_out, 32'h12345678);

    // Invalid requests: no source, then two sources.
    tick(1'b1, '0, oh(2), 1'b0, 1'b0, acc);
    rs = '0;
    rs[1:0] = 2'b11;
    tick(1'b1, rs, oh(2), 1'b0, 1'b0, acc);
    idle(4);
    chk("invalid_hold", bus_out, 32'h12345678);

    // FIFO full: offer four requests back to back, each held until taken.
    for (int k = 0; k < 4; k++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) tick(1'b1, oh(k + 8), oh(k + 12), 1'b0, 1'b0, acc);
    end
    idle(10);

    // Clear while the second transfer is in SELECT and a third is queued.
    tick(1'b1, oh(6), oh(7), 1'b0, 1'b0, acc);
    tick(1'b1, oh(8), oh(9), 1'b0, 1'b0, acc);
    tick(1'b1, oh(10), oh(11), 1'b0, 1'b0, acc);
    tick(1'b0, '0, '0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, acc);
      chk("clear_no_enable", {8'd0, reg_enable}, 32'h0);
    end
    chk("clear_bus", bus_out, 32'h0);
    chk("clear_busy", {31'd0, busy}, 32'h0);

    // Randomised traffic with bus-source churn and occasional clears.
    for (int n = 0; n < 500; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) begin
        t32 = $urandom;
        rs  = t32[NS-1:0];
      end else begin
        rs = oh($urandom_range(0, NS-1));
      end
      if ($urandom_range(0, 9) == 0) begin
        t32 = $urandom;
        rd  = t32[ND-1:0];
      end else begin
        rd = oh($urandom_range(0, ND-1));
      end
      tick(rv, rs, rd, rc, 1'b1, acc);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
